gf_addsub_pipe: RTL and testbench

//  Pipelined modular adder/subtractor over GF(P): r = (a + b) mod P or (a - b) mod P, operands in [0,P).

---
 rtl/gf_addsub_pipe_pkg.sv | 14 +
 rtl/gf_addsub_pipe_stage.sv | 41 ++++
 rtl/gf_addsub_pipe.sv | 107 ++++++++++
 tb/tb_gf_addsub_pipe.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf_addsub_pipe_pkg.sv
// Shared GF arithmetic definitions: secp256k1 field prime, add/sub op encoding, default width.
package gf_pkg;

  localparam int unsigned GF_WIDTH = 256;

  localparam logic [255:0] P_SECP256K1 =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } gf_op_e;

endpackage

// File: rtl/gf_addsub_pipe_stage.sv
// Generic valid/ready pipeline register; accepts a new beat whenever empty or draining.
module gf_addsub_stage #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;

  always_comb begin
    in_ready = !valid_q || out_ready;
    valid_d  = valid_q;
    data_d   = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) data_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/gf_addsub_pipe.sv
// Two-stage pipelined modular add/sub over GF(P) with tag passthrough.
// Optional operand range check (out_err) enabled by GF_ADDSUB_RANGE_CHK_EN.
module gf_addsub_pipe
  import gf_pkg::*;
#(
  parameter int unsigned      WIDTH = GF_WIDTH,
  parameter logic [WIDTH-1:0] P     = P_SECP256K1[WIDTH-1:0],
  parameter int unsigned      TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_r,
`ifdef GF_ADDSUB_RANGE_CHK_EN
  output logic             out_err,
`endif
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned    XW  = WIDTH + 1;
  localparam logic [XW-1:0]  P_X = {1'b0, P};
`ifdef GF_ADDSUB_RANGE_CHK_EN
  localparam int unsigned    S1_W = 2 * XW + 1 + TAG_W + 1;
  localparam int unsigned    S2_W = WIDTH + TAG_W + 1;
`else
  localparam int unsigned    S1_W = 2 * XW + 1 + TAG_W;
  localparam int unsigned    S2_W = WIDTH + TAG_W;
`endif

  gf_op_e          op;
  logic [XW-1:0]   a_x, b_x, raw_d, alt_d;
  logic [XW-1:0]   s1_raw, s1_alt;
  logic            s1_op;
  logic [TAG_W-1:0] s1_tag;
  logic [WIDTH-1:0] r_d;
  logic [S1_W-1:0] s1_in, s1_out;
  logic [S2_W-1:0] s2_in, s2_out;
  logic            s1_valid, s2_ready;

  assign op = gf_op_e'(in_op);

  // Both candidates are formed up front; stage 2 only selects using the sign bits.
  always_comb begin
    a_x = {1'b0, in_a};
    b_x = {1'b0, in_b};
    if (op == OP_SUB) begin
      raw_d = a_x - b_x;
      alt_d = raw_d + P_X;
    end else begin
      raw_d = a_x + b_x;
      alt_d = raw_d - P_X;
    end
  end

`ifdef GF_ADDSUB_RANGE_CHK_EN
  logic err_d, s1_err;
  assign err_d = (in_a >= P) || (in_b >= P);
  assign s1_in = {raw_d, alt_d, in_op, in_tag, err_d};
  assign {s1_raw, s1_alt, s1_op, s1_tag, s1_err} = s1_out;
  assign s2_in = {r_d, s1_tag, s1_err};
  assign {out_r, out_tag, out_err} = s2_out;
`else
  assign s1_in = {raw_d, alt_d, in_op, in_tag};
  assign {s1_raw, s1_alt, s1_op, s1_tag} = s1_out;
  assign s2_in = {r_d, s1_tag};
  assign {out_r, out_tag} = s2_out;
`endif

  always_comb begin
    r_d = s1_raw[WIDTH-1:0];
    if (gf_op_e'(s1_op) == OP_SUB) begin
      if (s1_raw[WIDTH]) r_d = s1_alt[WIDTH-1:0];
    end else if (!s1_alt[WIDTH]) begin
      r_d = s1_alt[WIDTH-1:0];
    end
  end

  gf_addsub_stage #(.DW(S1_W)) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_in),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_out)
  );

  gf_addsub_stage #(.DW(S2_W)) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   (s2_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_out)
  );

endmodule

// File: tb/tb_gf_addsub_pipe.sv
// Bench for gf_addsub_pipe: 256-bit secp256k1 instance and 8-bit P=251 instance vs a modular reference model.
module tb_gf_addsub_pipe;

  localparam logic [255:0] P256 = gf_pkg::P_SECP256K1;
  localparam int P8 = 251;

  typedef struct packed {
    logic [255:0] r;
    logic [3:0]   tag;
    logic         err;
    logic         chk_r;
  } exp256_t;

  typedef struct packed {
    logic [7:0] r;
    logic [3:0] tag;
  } exp8_t;

  logic clk, rst_n;
  int n_cmp, n_fail;

  logic         v256, ir256, op256, ov256, ordy256;
  logic [255:0] a256, b256, r256;
  logic [3:0]   tagi256, tago256;
  logic         v8, ir8, op8, ov8, ordy8;
  logic [7:0]   a8, b8, r8;
  logic [3:0]   tagi8, tago8;
`ifdef GF_ADDSUB_RANGE_CHK_EN
  logic err256, err8;
`endif

  exp256_t q256[$];
  exp8_t   q8[$];

  gf_addsub_pipe dut256 (
    .clk(clk), .rst_n(rst_n), .in_valid(v256), .in_ready(ir256), .in_op(op256),
    .in_a(a256), .in_b(b256), .in_tag(tagi256), .out_valid(ov256), .out_ready(ordy256),
    .out_r(r256),
`ifdef GF_ADDSUB_RANGE_CHK_EN
    .out_err(err256),
`endif
    .out_tag(tago256)
  );

  gf_addsub_pipe #(.WIDTH(8), .P(8'd251), .TAG_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(ir8), .in_op(op8),
    .in_a(a8), .in_b(b8), .in_tag(tagi8), .out_valid(ov8), .out_ready(ordy8),
    .out_r(r8),
`ifdef GF_ADDSUB_RANGE_CHK_EN
    .out_err(err8),
`endif
    .out_tag(tago8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] ref256(input logic op, input logic [255:0] a, input logic [255:0] b);
    logic [256:0] s;
    if (!op) begin
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, P256}) s = s - {1'b0, P256};
    end else if (a >= b) begin
      s = {1'b0, a} - {1'b0, b};
    end else begin
      s = {1'b0, a} + {1'b0, P256} - {1'b0, b};
    end
    return s[255:0];
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] x;
    for (int unsigned i = 0; i < 8; i++) x[32*i +: 32] = $urandom;
    if (x >= P256) x = x - P256;
    return x;
  endfunction

  // Drive inputs after the falling edge, then sample outputs 1ns later.
  task automatic drive256(input logic iv, input logic op, input logic [255:0] a, input logic [255:0] b,
                          input logic [3:0] tag, input logic ordy);
    @(negedge clk);
    v256 = iv; op256 = op; a256 = a; b256 = b; tagi256 = tag; ordy256 = ordy;
    #1;
  endtask

  task automatic drive8(input logic iv, input logic op, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] tag, input logic ordy);
    @(negedge clk);
    v8 = iv; op8 = op; a8 = a; b8 = b; tagi8 = tag; ordy8 = ordy;
    #1;
  endtask

  function automatic exp256_t mk256(input logic op, input logic [255:0] a, input logic [255:0] b,
                                    input logic [3:0] tag);
    exp256_t e;
    e.r = ref256(op, a, b);
    e.tag = tag;
    e.err = (a >= P256) || (b >= P256);
    e.chk_r = !e.err;
    return e;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    v256 = 0; op256 = 0; a256 = '0; b256 = '0; tagi256 = '0; ordy256 = 0;
    v8 = 0; op8 = 0; a8 = '0; b8 = '0; tagi8 = '0; ordy8 = 0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (ov256 !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", ov256); end
    n_cmp++; if (r256 !== '0) begin n_fail++; $display("FAIL reset_r got=%h exp=0", r256); end
    n_cmp++; if (tago256 !== '0) begin n_fail++; $display("FAIL reset_tag got=%h exp=0", tago256); end
    n_cmp++; if (ov8 !== 1'b0) begin n_fail++; $display("FAIL reset_valid8 got=%b exp=0", ov8); end
`ifdef GF_ADDSUB_RANGE_CHK_EN
    n_cmp++; if (err256 !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err256); end
`endif
    rst_n = 1'b1;
    #1;
    n_cmp++; if (ir256 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", ir256); end
  endtask

  task automatic test_boundaries();
    logic         ops [7];
    logic [255:0] as  [7];
    logic [255:0] bs  [7];
    logic [255:0] exs [7];
    logic [255:0] x, rr;
    int lat;
    x  = {{15{16'h7FFF}}, 16'hFE18};
    rr = rand256();
    ops[0] = 1; as[0] = '0;       bs[0] = 256'd1;    exs[0] = P256 - 256'd1;
    ops[1] = 0; as[1] = P256 - 1; bs[1] = 256'd1;    exs[1] = '0;
    ops[2] = 0; as[2] = P256 - 1; bs[2] = P256 - 1;  exs[2] = P256 - 256'd2;
    ops[3] = 1; as[3] = x;        bs[3] = x;         exs[3] = '0;
    ops[4] = 1; as[4] = '0;       bs[4] = '0;        exs[4] = '0;
    ops[5] = 1; as[5] = rr;       bs[5] = rr;        exs[5] = '0;
    ops[6] = 0; as[6] = '0;       bs[6] = '0;        exs[6] = '0;
    for (int i = 0; i < 7; i++) begin
      drive256(1, ops[i], as[i], bs[i], 4'(i + 3), 1);
      n_cmp++; if (ir256 !== 1'b1) begin n_fail++; $display("FAIL bnd_in_ready[%0d] got=%b exp=1", i, ir256); end
      lat = 0;
      for (int k = 1; k <= 6; k++) begin
        drive256(0, 0, '0, '0, '0, 1);
        if (ov256 === 1'b1) begin lat = k; break; end
      end
      n_cmp++; if (lat != 2) begin n_fail++; $display("FAIL bnd_latency[%0d] got=%0d exp=2", i, lat); end
      n_cmp++; if (r256 !== exs[i]) begin n_fail++; $display("FAIL bnd_r[%0d] got=%h exp=%h", i, r256, exs[i]); end
      n_cmp++; if (tago256 !== 4'(i + 3)) begin n_fail++; $display("FAIL bnd_tag[%0d] got=%h exp=%h", i, tago256, 4'(i + 3)); end
    end
    drive256(0, 0, '0, '0, '0, 1);
  endtask

  task automatic test_back_to_back();
    logic [255:0] a, b;
    logic op;
    exp256_t e;
    q256.delete();
    for (int c = 0; c < 12; c++) begin
      if (c < 8) begin
        a = rand256(); b = rand256(); op = 1'($urandom);
        drive256(1, op, a, b, 4'(c), 1);
        n_cmp++; if (ir256 !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d] got=%b exp=1", c, ir256); end
        q256.push_back(mk256(op, a, b, 4'(c)));
      end else begin
        drive256(0, 0, '0, '0, '0, 1);
      end
      n_cmp++;
      if (ov256 !== ((c >= 2) && (c < 10))) begin
        n_fail++; $display("FAIL b2b_valid[%0d] got=%b exp=%b", c, ov256, (c >= 2) && (c < 10));
      end
      if (ov256 === 1'b1 && q256.size() > 0) begin
        e = q256.pop_front();
        n_cmp++; if (r256 !== e.r) begin n_fail++; $display("FAIL b2b_r[%0d] got=%h exp=%h", c, r256, e.r); end
        n_cmp++; if (tago256 !== e.tag) begin n_fail++; $display("FAIL b2b_tag[%0d] got=%h exp=%h", c, tago256, e.tag); end
      end
    end
  endtask

  task automatic test_stall();
    logic [255:0] a, b, held_r;
    logic [3:0] held_t;
    logic op, have;
    int acc, seen;
    exp256_t e;
    q256.delete();
    acc = 0; have = 0; seen = 0;
    for (int c = 0; c < 6; c++) begin
      a = rand256(); b = rand256(); op = 1'($urandom);
      drive256(1, op, a, b, 4'(8 + c), 0);
      if (ir256 === 1'b1) begin q256.push_back(mk256(op, a, b, 4'(8 + c))); acc++; end
      if (ov256 === 1'b1) begin
        if (have) begin
          n_cmp++; if (r256 !== held_r) begin n_fail++; $display("FAIL stall_r_stable[%0d] got=%h exp=%h", c, r256, held_r); end
          n_cmp++; if (tago256 !== held_t) begin n_fail++; $display("FAIL stall_tag_stable[%0d] got=%h exp=%h", c, tago256, held_t); end
        end
        held_r = r256; held_t = tago256; have = 1;
      end
    end
    n_cmp++; if (acc != 2) begin n_fail++; $display("FAIL stall_accepted got=%0d exp=2", acc); end
    n_cmp++; if (ir256 !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready got=%b exp=0", ir256); end
    n_cmp++; if (ov256 !== 1'b1) begin n_fail++; $display("FAIL stall_out_valid got=%b exp=1", ov256); end
    // Full pipe with both handshakes in the same cycle.
    a = rand256(); b = rand256(); op = 1'($urandom);
    drive256(1, op, a, b, 4'hF, 1);
    n_cmp++; if (ir256 !== 1'b1) begin n_fail++; $display("FAIL full_pipe_in_ready got=%b exp=1", ir256); end
    if (ir256 === 1'b1) q256.push_back(mk256(op, a, b, 4'hF));
    if (ov256 === 1'b1 && q256.size() > 0) begin
      e = q256.pop_front(); seen++;
      n_cmp++; if (r256 !== e.r) begin n_fail++; $display("FAIL stall_r got=%h exp=%h", r256, e.r); end
      n_cmp++; if (tago256 !== e.tag) begin n_fail++; $display("FAIL stall_tag got=%h exp=%h", tago256, e.tag); end
    end
    for (int c = 0; c < 8; c++) begin
      drive256(0, 0, '0, '0, '0, 1);
      if (ov256 === 1'b1) begin
        seen++;
        if (q256.size() == 0) begin
          n_cmp++; n_fail++; $display("FAIL stall_dup got=tag%h exp=none", tago256);
        end else begin
          e = q256.pop_front();
          n_cmp++; if (r256 !== e.r) begin n_fail++; $display("FAIL stall_drain_r got=%h exp=%h", r256, e.r); end
          n_cmp++; if (tago256 !== e.tag) begin n_fail++; $display("FAIL stall_drain_tag got=%h exp=%h", tago256, e.tag); end
        end
      end
    end
    n_cmp++; if (seen != 3) begin n_fail++; $display("FAIL stall_count got=%0d exp=3", seen); end
  endtask

  task automatic test_reset_midflight();
    drive256(1, 0, rand256(), rand256(), 4'h1, 0);
    drive256(1, 1, rand256(), rand256(), 4'h2, 0);
    drive256(0, 0, '0, '0, '0, 0);
    n_cmp++; if (ov256 !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre_valid got=%b exp=1", ov256); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (ov256 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_async_valid got=%b exp=0", ov256); end
    n_cmp++; if (r256 !== '0) begin n_fail++; $display("FAIL rst_mid_async_r got=%h exp=0", r256); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      drive256(0, 0, '0, '0, '0, 1);
      n_cmp++; if (ov256 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stale[%0d] got=%b exp=0", c, ov256); end
    end
    n_cmp++; if (ir256 !== 1'b1) begin n_fail++; $display("FAIL rst_mid_in_ready got=%b exp=1", ir256); end
    q256.delete();
  endtask

`ifdef GF_ADDSUB_RANGE_CHK_EN
  task automatic test_range_err();
    logic [255:0] a, b;
    exp256_t e;
    int seen;
    q256.delete();
    seen = 0;
    drive256(1, 0, P256, '0, 4'h3, 1);
    q256.push_back(mk256(0, P256, '0, 4'h3));
    a = rand256(); b = rand256();
    drive256(1, 1, a, b, 4'h4, 1);
    q256.push_back(mk256(1, a, b, 4'h4));
    for (int c = 0; c < 6; c++) begin
      drive256(0, 0, '0, '0, '0, 1);
      if (ov256 === 1'b1 && q256.size() > 0) begin
        e = q256.pop_front(); seen++;
        n_cmp++; if (err256 !== e.err) begin n_fail++; $display("FAIL range_err[%0d] got=%b exp=%b", seen, err256, e.err); end
        n_cmp++; if (tago256 !== e.tag) begin n_fail++; $display("FAIL range_tag[%0d] got=%h exp=%h", seen, tago256, e.tag); end
        if (e.chk_r) begin
          n_cmp++; if (r256 !== e.r) begin n_fail++; $display("FAIL range_r[%0d] got=%h exp=%h", seen, r256, e.r); end
        end
      end
    end
    n_cmp++; if (seen != 2) begin n_fail++; $display("FAIL range_count got=%0d exp=2", seen); end
  endtask
`endif

  task automatic test_exhaustive8();
    exp8_t e;
    int cnt, tries;
    logic done, ordy;
    q8.delete();
    cnt = 0;
    for (int op = 0; op < 2; op++) begin
      for (int a = 0; a < P8; a++) begin
        if (!((a % 5) == 0 || a == 1 || a == P8 - 2)) continue;
        for (int b = 0; b < P8; b++) begin
          done = 0; tries = 0;
          while (!done) begin
            ordy = ($urandom_range(0, 3) != 0);
            drive8(1, 1'(op), 8'(a), 8'(b), 4'(cnt), ordy);
            if (ov8 === 1'b1 && ordy && q8.size() > 0) begin
              e = q8.pop_front();
              n_cmp++;
              if (r8 !== e.r || tago8 !== e.tag) begin
                n_fail++; $display("FAIL ex8_r got=%0d/tag%h exp=%0d/tag%h", r8, tago8, e.r, e.tag);
              end
            end
            if (ir8 === 1'b1) begin
              e.r = (op == 0) ? 8'((a + b) % P8) : 8'((a - b + P8) % P8);
              e.tag = 4'(cnt);
              q8.push_back(e);
              cnt++; done = 1;
            end
            tries++;
            if (!done && tries > 30) begin
              n_cmp++; n_fail++; $display("FAIL ex8_accept_timeout got=in_ready0 exp=in_ready1");
              done = 1;
            end
          end
        end
      end
    end
    for (int c = 0; c < 10; c++) begin
      drive8(0, 0, '0, '0, '0, 1);
      if (ov8 === 1'b1 && q8.size() > 0) begin
        e = q8.pop_front();
        n_cmp++;
        if (r8 !== e.r || tago8 !== e.tag) begin
          n_fail++; $display("FAIL ex8_drain got=%0d/tag%h exp=%0d/tag%h", r8, tago8, e.r, e.tag);
        end
      end
    end
    n_cmp++; if (q8.size() != 0) begin n_fail++; $display("FAIL ex8_leftover got=%0d exp=0", q8.size()); end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    test_reset();
    test_boundaries();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
`ifdef GF_ADDSUB_RANGE_CHK_EN
    test_range_err();
`endif
    test_exhaustive8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
